// File: rtl/fan_sum_drain_if.sv
// Handshake bundle between the FAN reduction tree, fan_sum_drain and the
// downstream result consumer.
interface fan_sum_drain_if #(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int V  = 3,
  parameter int S  = W + $clog2(N),
  parameter int IW = $clog2(N - 1)
);
  logic                    in_valid;
  logic                    in_ready;
  logic [N-2:0][S-1:0]     in_sums;
  logic [N-2:0]            in_valids;
  logic [N-1:0][V-1:0]     in_vec_ids;
  logic                    out_valid;
  logic                    out_ready;
  logic [S-1:0]            out_sum;
  logic [V-1:0]            out_vec_id;
  logic [IW-1:0]           out_idx;
  logic                    out_last;

  modport master (
    output in_valid, in_sums, in_valids, in_vec_ids, out_ready,
    input  in_ready, out_valid, out_sum, out_vec_id, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_sums, in_valids, in_vec_ids, out_ready,
    output in_ready, out_valid, out_sum, out_vec_id, out_idx, out_last
  );
endinterface

// File: rtl/fan_sum_drain.sv
// Registers one FAN result bundle and drains its valid sums, lowest index
// first, as a dense valid/ready stream tagged with the group vec_id.
module fan_sum_drain #(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int V  = 3,
  parameter int S  = W + $clog2(N),
  parameter int IW = $clog2(N - 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  fan_sum_drain_if.slave  bus
);

  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [N-2:0] FORCED = {1'b1, {(N-2){1'b0}}};

  state_t              state, state_next;
  logic [N-2:0]        mask_q, mask_next;
  logic [N-2:0][S-1:0] sums_q;
  logic [N-2:0][V-1:0] vec_q;
  logic [IW-1:0]       k;
  logic [N-2:0]        k_onehot;
  logic                has_k;
  logic                last;
  logic                fire;
  logic                capture;
  logic                vec0_unused;

  // Operand 0 never tags a group: sum idx is tagged with operand idx+1.
  assign vec0_unused = ^bus.in_vec_ids[0];

  always_comb begin
    k        = '0;
    k_onehot = '0;
    has_k    = 1'b0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (mask_q[i] && !has_k) begin
        k           = IW'(i);
        k_onehot[i] = 1'b1;
        has_k       = 1'b1;
      end
    end
  end

  assign last    = has_k && ((mask_q & ~k_onehot) == '0);
  assign fire    = bus.out_valid && bus.out_ready;
  assign capture = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      mask_q <= '0;
    end else begin
      state  <= state_next;
      mask_q <= mask_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sums_q <= '0;
      vec_q  <= '0;
    end else if (capture) begin
      sums_q <= bus.in_sums;
      vec_q  <= bus.in_vec_ids[N-1:1];
    end
  end

  // A capture can only coincide with the final beat, so it simply replaces
  // the (then empty) mask and keeps the state in DRAIN.
  always_comb begin
    state_next = state;
    mask_next  = mask_q;
    if (capture) begin
      state_next = DRAIN;
      mask_next  = bus.in_valids | FORCED;
    end else if (fire) begin
      mask_next = mask_q & ~k_onehot;
      if (last) state_next = IDLE;
    end
  end

  always_comb begin
    bus.out_valid  = (state == DRAIN);
    bus.out_sum    = '0;
    bus.out_vec_id = '0;
    bus.out_idx    = '0;
    bus.out_last   = 1'b0;
    if (bus.out_valid) begin
      bus.out_sum    = sums_q[k];
      bus.out_vec_id = vec_q[k];
      bus.out_idx    = k;
      bus.out_last   = last;
    end
    bus.in_ready = (state == IDLE) || (fire && last);
  end

endmodule
